// File: rtl/efx_gpio_pkg.sv
// Shared constants and helpers for the efx_gpio_model I/O cell.
package efx_gpio_pkg;

  // Pad direction selectors for the TYPE parameter.
  localparam string TYPE_IN    = "IN";
  localparam string TYPE_OUT   = "OUT";
  localparam string TYPE_INOUT = "INOUT";

  // Active polarity of a path clock: 1 = rising edge is active, 0 = falling.
  function automatic logic active_pol(input logic inv);
    return !inv;
  endfunction

  // Clock seen by a path so that its active edge is always a posedge.
  function automatic logic edge_clk(input logic clk, input logic inv);
    return active_pol(inv) ? clk : !clk;
  endfunction

endpackage

// File: rtl/efx_ddio_reg.sv
// Dual-edge register pair: HI captured on the active edge, LO on the
// opposite edge, both cleared asynchronously by rst_ni.
module efx_ddio_reg
  import efx_gpio_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter bit INV   = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_hi_i,
  input  logic [WIDTH-1:0] d_lo_i,
  output logic [WIDTH-1:0] q_hi_o,
  output logic [WIDTH-1:0] q_lo_o
);

  logic             ck;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  assign ck = edge_clk(clk_i, INV);

  // Active-edge capture of the HI half.
  always_ff @(posedge ck or negedge rst_ni) begin
    if (!rst_ni) hi_q <= '0;
    else         hi_q <= d_hi_i;
  end

  // Opposite-edge capture of the LO half.
  always_ff @(negedge ck or negedge rst_ni) begin
    if (!rst_ni) lo_q <= '0;
    else         lo_q <= d_lo_i;
  end

  assign q_hi_o = hi_q;
  assign q_lo_o = lo_q;

endmodule

// File: rtl/efx_gpio_model.sv
// Configurable vendor I/O cell model: output, output-enable and input paths,
// each combinational, single-edge registered or DDIO, on one shared clock.
module efx_gpio_model
  import efx_gpio_pkg::*;
#(
  parameter int    BUS_WIDTH  = 1,
  parameter string TYPE       = "OUT",
  parameter bit    OUT_REG    = 1'b1,
  parameter bit    OUT_DDIO   = 1'b0,
  parameter bit    OUT_RESYNC = 1'b0,
  parameter bit    OUTCLK_INV = 1'b0,
  parameter bit    OE_REG     = 1'b0,
  parameter bit    IN_REG     = 1'b0,
  parameter bit    IN_DDIO    = 1'b0,
  parameter bit    IN_RESYNC  = 1'b0,
  parameter bit    INCLK_INV  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BUS_WIDTH-1:0] out_HI,
  input  logic [BUS_WIDTH-1:0] out_LO,
  input  logic                 oe,
  output logic [BUS_WIDTH-1:0] in_HI,
  output logic [BUS_WIDTH-1:0] in_LO,
  inout  wire  [BUS_WIDTH-1:0] io
);

  localparam int W = BUS_WIDTH;

  // Per-path clocks whose posedge is the path's active edge.
  logic ck_o;
  logic ck_i;
  assign ck_o = edge_clk(clk, OUTCLK_INV);
  assign ck_i = edge_clk(clk, INCLK_INV);

  logic [W-1:0] drv;
  logic         oe_eff;

  // ---------------- output data path ----------------
  if (OUT_REG && OUT_DDIO) begin : g_out_ddio
    logic [W-1:0] hi_q;
    logic [W-1:0] lo_q;
    logic [W-1:0] lo_d;

    if (OUT_RESYNC) begin : g_resync
      logic [W-1:0] lo_s_q;
      // Resync stage: take out_LO on the active edge so the opposite-edge
      // flop sees a value that was stable for a half cycle.
      always_ff @(posedge ck_o or negedge rst_n) begin
        if (!rst_n) lo_s_q <= '0;
        else        lo_s_q <= out_LO;
      end
      assign lo_d = lo_s_q;
    end else begin : g_direct
      assign lo_d = out_LO;
    end

    efx_ddio_reg #(.WIDTH(W), .INV(OUTCLK_INV)) u_out_ddio (
      .clk_i (clk),
      .rst_ni(rst_n),
      .d_hi_i(out_HI),
      .d_lo_i(lo_d),
      .q_hi_o(hi_q),
      .q_lo_o(lo_q)
    );

    // HI in the half cycle after the active edge, LO after the opposite one.
    assign drv = (clk ^ OUTCLK_INV) ? hi_q : lo_q;
  end else if (OUT_REG) begin : g_out_sdr
    logic [W-1:0] hi_q;
    // Single-edge output register.
    always_ff @(posedge ck_o or negedge rst_n) begin
      if (!rst_n) hi_q <= '0;
      else        hi_q <= out_HI;
    end
    assign drv = hi_q;
  end else begin : g_out_comb
    assign drv = out_HI;
  end

  // ---------------- output enable ----------------
  if (OE_REG) begin : g_oe_reg
    logic oe_q;
    // Registered enable, cleared in reset so the pad tri-states.
    always_ff @(posedge ck_o or negedge rst_n) begin
      if (!rst_n) oe_q <= 1'b0;
      else        oe_q <= oe;
    end
    assign oe_eff = oe_q;
  end else begin : g_oe_comb
    assign oe_eff = oe;
  end

  // ---------------- pad driver ----------------
  if (TYPE == TYPE_OUT) begin : g_pad_out
    assign io = drv;
  end else if (TYPE == TYPE_INOUT) begin : g_pad_inout
    assign io = oe_eff ? drv : {W{1'bz}};
  end else begin : g_pad_in
    assign io = {W{1'bz}};
  end

  // ---------------- input path ----------------
  if (TYPE == TYPE_OUT) begin : g_in_none
    assign in_HI = '0;
    assign in_LO = '0;
  end else if (!IN_REG) begin : g_in_comb
    assign in_HI = io;
    assign in_LO = io;
  end else if (!IN_DDIO) begin : g_in_sdr
    logic [W-1:0] in_hi_q;
    // Single-edge input capture; LO mirrors HI.
    always_ff @(posedge ck_i or negedge rst_n) begin
      if (!rst_n) in_hi_q <= '0;
      else        in_hi_q <= io;
    end
    assign in_HI = in_hi_q;
    assign in_LO = in_hi_q;
  end else if (!IN_RESYNC) begin : g_in_ddio
    efx_ddio_reg #(.WIDTH(W), .INV(INCLK_INV)) u_in_ddio (
      .clk_i (clk),
      .rst_ni(rst_n),
      .d_hi_i(io),
      .d_lo_i(io),
      .q_hi_o(in_HI),
      .q_lo_o(in_LO)
    );
  end else begin : g_in_ddio_rs
    logic [W-1:0] hc_q;
    logic [W-1:0] lc_q;
    logic [W-1:0] in_hi_q;
    logic [W-1:0] in_lo_q;

    efx_ddio_reg #(.WIDTH(W), .INV(INCLK_INV)) u_in_ddio (
      .clk_i (clk),
      .rst_ni(rst_n),
      .d_hi_i(io),
      .d_lo_i(io),
      .q_hi_o(hc_q),
      .q_lo_o(lc_q)
    );

    // Realign the HI/LO pair so both halves update together on Ei.
    always_ff @(posedge ck_i or negedge rst_n) begin
      if (!rst_n) begin
        in_hi_q <= '0;
        in_lo_q <= '0;
      end else begin
        in_hi_q <= hc_q;
        in_lo_q <= lc_q;
      end
    end
    assign in_HI = in_hi_q;
    assign in_LO = in_lo_q;
  end

  // Inputs and clocks left unused by some parameter sets.
  logic unused_sink;
  assign unused_sink = ^{out_LO, oe, io, ck_i, ck_o, oe_eff};

endmodule

// File: tb/tb_efx_gpio_model.sv
// Bench for efx_gpio_model: several parameterisations on one clock.
module tb_efx_gpio_model;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- stimulus and nets ----------------
  logic [15:0] o16_hi, o16_lo;
  logic        o16_oe;
  logic [1:0]  pad2_val;

  wire  [0:0]  pad_sdr, pad_ddr;
  tri1  [15:0] pad16;
  wire  [1:0]  pad_rs, pad_nrs;

  wire  [0:0]  unused_sdr_hi, unused_sdr_lo, unused_ddr_hi, unused_ddr_lo;
  wire  [15:0] io16_in_hi, io16_in_lo;
  wire  [1:0]  rs_hi, rs_lo, nrs_hi, nrs_lo;

  assign pad_rs  = pad2_val;
  assign pad_nrs = pad2_val;

  efx_gpio_model #(.BUS_WIDTH(1), .TYPE("OUT"), .OUT_REG(1'b1)) u_out_sdr (
    .clk(clk), .rst_n(rst_n), .out_HI(1'b1), .out_LO(1'b0), .oe(1'b0),
    .in_HI(unused_sdr_hi), .in_LO(unused_sdr_lo), .io(pad_sdr));

  efx_gpio_model #(.BUS_WIDTH(1), .TYPE("OUT"), .OUT_REG(1'b1), .OUT_DDIO(1'b1),
                   .OUTCLK_INV(1'b1)) u_out_ddr (
    .clk(clk), .rst_n(rst_n), .out_HI(1'b1), .out_LO(1'b0), .oe(1'b0),
    .in_HI(unused_ddr_hi), .in_LO(unused_ddr_lo), .io(pad_ddr));

  efx_gpio_model #(.BUS_WIDTH(16), .TYPE("INOUT"), .OUT_REG(1'b1), .OUT_DDIO(1'b1),
                   .OE_REG(1'b1), .IN_REG(1'b1), .IN_DDIO(1'b1)) u_io16 (
    .clk(clk), .rst_n(rst_n), .out_HI(o16_hi), .out_LO(o16_lo), .oe(o16_oe),
    .in_HI(io16_in_hi), .in_LO(io16_in_lo), .io(pad16));

  efx_gpio_model #(.BUS_WIDTH(2), .TYPE("INOUT"), .IN_REG(1'b1), .IN_DDIO(1'b1),
                   .IN_RESYNC(1'b1)) u_in_rs (
    .clk(clk), .rst_n(rst_n), .out_HI(2'b00), .out_LO(2'b00), .oe(1'b0),
    .in_HI(rs_hi), .in_LO(rs_lo), .io(pad_rs));

  efx_gpio_model #(.BUS_WIDTH(2), .TYPE("INOUT"), .IN_REG(1'b1), .IN_DDIO(1'b1),
                   .IN_RESYNC(1'b0)) u_in_nrs (
    .clk(clk), .rst_n(rst_n), .out_HI(2'b00), .out_LO(2'b00), .oe(1'b0),
    .in_HI(nrs_hi), .in_LO(nrs_lo), .io(pad_nrs));

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Released 16-bit pad reads as all ones through the tri1 pull.
  localparam logic [15:0] PAD_Z = 16'hFFFF;

  typedef struct {
    logic [15:0] hi;
    logic [15:0] lo;
    logic        oe;
    logic [15:0] exp_pos;
    logic [15:0] exp_neg;
  } vec_t;

  vec_t vecs[6];

  // Pending {Ei sample, Ei' sample} pairs for the resynced input path.
  logic [3:0] exp_q[$];

  initial begin
    logic [1:0] a, b;
    logic [3:0] pair;

    vecs[0] = '{16'h1122, 16'h3344, 1'b1, 16'h1122, 16'h3344};
    vecs[1] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'hA5A5, 16'h5A5A};
    vecs[2] = '{16'h1122, 16'h3344, 1'b0, PAD_Z,    PAD_Z};
    vecs[3] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0F0F, 16'hF0F0};
    vecs[4] = '{16'hDEAD, 16'hBEEF, 1'b0, PAD_Z,    PAD_Z};
    vecs[5] = '{16'h0001, 16'h8000, 1'b1, 16'h0001, 16'h8000};

    o16_hi = '0; o16_lo = '0; o16_oe = 1'b1; pad2_val = 2'b11;

    // Reset state (edges at 5 and 15 occur while held in reset).
    #17;
    check("rst_sdr_pad",  16'(pad_sdr), 16'h0);
    check("rst_ddr_pad",  16'(pad_ddr), 16'h0);
    check("rst_io16_pad", pad16, PAD_Z);
    check("rst_io16_in_hi", io16_in_hi, 16'h0);
    check("rst_rs_hi",  16'(rs_hi),  16'h0);
    check("rst_nrs_lo", 16'(nrs_lo), 16'h0);

    // Release between edges; nothing moves until the next edge.
    #5 rst_n = 1'b1;                         // t=22
    #1 check("rel_sdr_wait", 16'(pad_sdr), 16'h0);
    o16_oe = 1'b0;
    @(posedge clk); #1;                      // t=26
    check("rel_sdr_first_pos", 16'(pad_sdr), 16'h1);
    check("rel_ddr_pos", 16'(pad_ddr), 16'h0);
    @(negedge clk); #1;
    check("rel_ddr_neg", 16'(pad_ddr), 16'h1);

    // Table-driven output/enable vectors on the 16-bit INOUT cell.
    for (int i = 0; i < 6; i++) begin
      o16_hi = vecs[i].hi; o16_oe = vecs[i].oe;
      @(posedge clk); #1;
      check($sformatf("vec%0d_pad_pos", i), pad16, vecs[i].exp_pos);
      check("vec_sdr_pos", 16'(pad_sdr), 16'h1);
      check("vec_ddr_pos", 16'(pad_ddr), 16'h0);
      o16_lo = vecs[i].lo;
      @(negedge clk); #1;
      check($sformatf("vec%0d_pad_neg", i), pad16, vecs[i].exp_neg);
      check("vec_ddr_neg", 16'(pad_ddr), 16'h1);
    end

    // Hand sequence: 01 before posedge, 10 before negedge.
    pad2_val = 2'b01;
    @(posedge clk); #1;
    check("seq_nrs_hi", 16'(nrs_hi), 16'h1);
    pad2_val = 2'b10;
    @(negedge clk); #1;
    check("seq_nrs_lo", 16'(nrs_lo), 16'h2);
    pad2_val = 2'b11;
    @(posedge clk); #1;
    check("seq_rs_hi", 16'(rs_hi), 16'h1);
    check("seq_rs_lo", 16'(rs_lo), 16'h2);
    @(negedge clk); #1;

    // Randomized traffic against the half-cycle reference model.
    exp_q.delete();
    for (int n = 0; n < 200; n++) begin
      a      = 2'($urandom_range(0, 3));
      o16_hi = 16'($urandom_range(0, 65535));
      o16_oe = ($urandom_range(0, 3) != 0);
      pad2_val = a;
      @(posedge clk); #1;
      check("rnd_pad_pos", pad16, o16_oe ? o16_hi : PAD_Z);
      check("rnd_nrs_hi", 16'(nrs_hi), 16'(a));
      if (exp_q.size() > 0) begin
        pair = exp_q.pop_front();
        check("rnd_rs_hi", 16'(rs_hi), 16'(pair[3:2]));
        check("rnd_rs_lo", 16'(rs_lo), 16'(pair[1:0]));
      end
      b      = 2'($urandom_range(0, 3));
      o16_lo = 16'($urandom_range(0, 65535));
      pad2_val = b;
      @(negedge clk); #1;
      check("rnd_pad_neg", pad16, o16_oe ? o16_lo : PAD_Z);
      check("rnd_nrs_lo", 16'(nrs_lo), 16'(b));
      exp_q.push_back({a, b});
    end

    // Reset mid-burst: everything clears without waiting for an edge.
    o16_hi = 16'h1234; o16_lo = 16'h5678; o16_oe = 1'b1; pad2_val = 2'b11;
    @(posedge clk); #1;
    check("burst_pad_live", pad16, 16'h1234);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_pad16", pad16, PAD_Z);
    check("mid_rst_io16_hi", io16_in_hi, 16'h0);
    check("mid_rst_io16_lo", io16_in_lo, 16'h0);
    check("mid_rst_rs_hi",  16'(rs_hi),  16'h0);
    check("mid_rst_rs_lo",  16'(rs_lo),  16'h0);
    check("mid_rst_nrs_hi", 16'(nrs_hi), 16'h0);
    check("mid_rst_nrs_lo", 16'(nrs_lo), 16'h0);
    check("mid_rst_sdr", 16'(pad_sdr), 16'h0);
    check("mid_rst_ddr", 16'(pad_ddr), 16'h0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/efx_gpio_model.md
# efx_gpio_model

Behavioural and synthesisable model of a vendor I/O cell with a configurable output path, output-enable path and input path. Each path can be combinational, single-edge registered or double-data-rate (DDIO), with optional clock inversion and resynchronisation. The cell sits between the HyperBus controller's split hi/lo data, RWDS, CK and CS signals and the bidirectional pad nets of the memory device. One instance handles a whole bus, with a shared `oe`.

## Interface
- `BUS_WIDTH`, 1: number of pad bits.
- `TYPE`, "OUT": "IN", "OUT" or "INOUT".
- `OUT_REG`, 1: register the output path.
- `OUT_DDIO`, 0: output DDR; requires `OUT_REG`=1.
- `OUT_RESYNC`, 0: capture `out_LO` on the active edge before the opposite-edge stage.
- `OUTCLK_INV`, 0: output active edge is falling.
- `OE_REG`, 0: register `oe`.
- `IN_REG`, 0: register the input path.
- `IN_DDIO`, 0: input DDR; requires `IN_REG`=1.
- `IN_RESYNC`, 0: realign the LO capture to the active edge.
- `INCLK_INV`, 0: input active edge is falling.

Ports:
- `clk` in 1: the single clock for all paths (replaces outclk/inclk).
- `rst_n` in 1: asynchronous, active-low reset.
- `out_HI` in BUS_WIDTH: data for the first half-cycle.
- `out_LO` in BUS_WIDTH: data for the second half-cycle.
- `oe` in 1: output enable for all bits.
- `in_HI` out BUS_WIDTH: data captured on the active edge.
- `in_LO` out BUS_WIDTH: data captured on the opposite edge.
- `io` inout BUS_WIDTH: pad.

## Operation
- Edge definitions:
  - Output active edge Eo = posedge clk, or negedge if `OUTCLK_INV`; Eo' is the opposite edge.
  - Input active edge Ei and its opposite Ei' are defined the same way using `INCLK_INV`.
- Output data:
  - `OUT_REG`=0: `drv` = `out_HI`, combinational.
  - `OUT_REG`=1, `OUT_DDIO`=0: `hi_q` <= `out_HI` at Eo; `drv` = `hi_q`.
  - DDIO: `hi_q` <= `out_HI` at Eo.
    - `OUT_RESYNC`=0: `lo_q` <= `out_LO` at Eo'.
    - `OUT_RESYNC`=1: `lo_s` <= `out_LO` at Eo, then `lo_q` <= `lo_s` at Eo'.
    - `drv` = `hi_q` during the half-cycle following Eo and `lo_q` during the half-cycle following Eo'. Select with (clk XOR OUTCLK_INV).
- Enable:
  - `oe_eff` = `oe`, or `oe_q` (<= `oe` at Eo) when `OE_REG`.
  - TYPE "OUT": the pad is always driven and `oe` is ignored.
  - TYPE "INOUT": `io` = `oe_eff` ? `drv` : 'z.
  - TYPE "IN": `io` is never driven.
- Input path (TYPE "IN"/"INOUT"; for "OUT", `in_HI`/`in_LO` are tied to 0):
  - `IN_REG`=0: `in_HI` = `in_LO` = `io`, combinational.
  - `IN_REG`=1, `IN_DDIO`=0: `in_HI` <= `io` at Ei; `in_LO` = `in_HI`.
  - DDIO, `IN_RESYNC`=0: `in_HI` <= `io` at Ei; `in_LO` <= `io` at Ei'.
  - DDIO, `IN_RESYNC`=1: `hc` <= `io` at Ei and `lc` <= `io` at Ei'. Then at the next Ei, `in_HI` <= `hc` and `in_LO` <= `lc`. The pair is the Ei sample followed by the Ei' sample half a cycle later, both updating on Ei.
- X/Z on `io` propagates unchanged into the captures.

## Timing
- Reset (`rst_n`=0, asynchronous): all registers (`hi_q`, `lo_q`, `lo_s`, `oe_q`, `hc`, `lc`, `in_HI`, `in_LO`) are cleared to 0.
  - Registered INOUT pad is tri-stated while `OE_REG`=1.
  - Registered OUT pad drives 0.
  - Release takes effect on the first edge after `rst_n` rises.
- Output latency:
  - `out_HI` appears on the pad at Eo.
  - `out_LO`, no resync: at Eo', from the value present at Eo'.
  - `out_LO`, resync: at Eo', from the value present at the preceding Eo.
  - `oe_q` takes effect at Eo.
- Input latency:
  - Registered SDR: 1 active edge.
  - DDIO no-resync: HI at Ei, LO at Ei'.
  - DDIO resync: both update one full cycle after the HI sample.
- Reset asserted mid-burst aborts the output immediately with no partial half-cycle hold.
- `rst_n` and a clock edge together: reset wins.

## Structure
- Package `efx_gpio_pkg`: TYPE string constants and an edge-select function (inv flag → active polarity).
- One sub-module, `efx_ddio_reg`: a BUS_WIDTH-wide dual-edge register pair with async active-low clear. It is used for both the output and input DDIO paths.

## Test plan
- OUT, SDR registered, BUS_WIDTH=1, `out_HI`=1 → pad goes to 1 at the first posedge after `rst_n` release; 0 during reset.
- OUT, DDIO, `OUTCLK_INV`=1, `out_HI`/`out_LO` = 1/0 each cycle → pad toggles 1 after negedge and 0 after posedge, i.e. a clock copy shifted by 180°.
- INOUT, BUS_WIDTH=16, DDIO both ways, `OE_REG`, `OUT_RESYNC`=0:
  - `oe`=1, `out_HI`=16'h1122, `out_LO`=16'h3344 → pad shows 1122 then 3344.
  - `oe`=0 → pad is 'z at the next posedge.
- INOUT, BUS_WIDTH=2, `IN_DDIO`+`IN_RESYNC`, pad driven externally 2'b01 before posedge and 2'b10 before negedge → `in_HI`=01 and `in_LO`=10 together at the following posedge.
- `IN_RESYNC`=0, same stimulus → `in_HI`=01 at the posedge and `in_LO`=10 at the negedge.
- Assert `rst_n`=0 mid-DDIO burst → all `in_*` go to 0 and the pad goes to 'z immediately, without waiting for a clock edge.
